lzrw1_compressor: RTL and testbench
===================================

# lzrw1_compressor

Streaming LZRW1 compressor core that produces the item stream consumed by the decompressor. Each item is either a literal or a copy. A literal is `{8'h00, byte}` with control bit 0. A copy is `{len-3[3:0], offset[11:0]}` with control bit 1. Input bytes arrive over a valid/busy handshake. The core finds matches through a direct-mapped hash table of 3-byte prefixes and a byte history buffer. It emits one item per `out_valid` pulse.

## Interface
Parameters:
- `HISTORY_SIZE`, default 256. History buffer depth in bytes. Power of 2, 32..4096. The maximum copy offset is `HISTORY_SIZE-1`.
- `HASH_ENTRIES`, default 64. Hash table depth. Power of 2, 16..4096.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `data_in`  in  8  uncompressed input byte.
- `data_in_valid`  in  1  `data_in` is valid.
- `data_in_last`  in  1  qualifies `data_in` as the final byte of the frame.
- `compressor_busy`  out  1  while 1, inputs are ignored. A byte is accepted on a rising edge where `data_in_valid=1` and `compressor_busy=0`.
- `data_out`  out  16  compressed item.
- `control_word_out`  out  1  0 = literal, 1 = copy.
- `out_valid`  out  1  one-cycle pulse per item.
- `done`  out  1  one-cycle pulse after the last item of a frame.

## Operation
**Storage**
- 18-byte lookahead shift register. Head = byte at stream position `cur` (16-bit, frame max 65535 bytes).
- History RAM, `HISTORY_SIZE` x 8, addressed by position mod `HISTORY_SIZE`. Bytes are written only when consumed by an emitted item.
- Hash table, `HASH_ENTRIES` x 16-bit position, plus a per-entry valid flop vector.
- Hash function: `h = (b0 ^ {b1[3:0],b1[7:4]} ^ {b2[1:0],b2[7:2]}) & (HASH_ENTRIES-1)`, where b0..b2 are the first three lookahead bytes.

**State machine**
- **FILL**
  - `compressor_busy=0` while `avail<18` and `last` has not been seen.
  - Leave FILL when `avail==18`, or when `last` has been seen and `avail>0`.
  - If `last` has been seen and `avail==0`, pulse `done` and perform frame clear: `cur=0`, all hash valid bits=0, `last` flag=0. Stay in FILL.
- **HASH**
  - If `avail<3`, go to EMIT with `len=0`.
  - Otherwise compute `h` and read entry `h`.
- **LOOKUP**
  - Candidate `p` = stored position.
  - Write `cur` to entry `h` and set its valid bit.
  - `off = cur - p` (16-bit).
  - If the entry was invalid, or `off==0`, or `off>HISTORY_SIZE-1`, go to EMIT with `len=0`. Otherwise go to COMPARE with `k=0`.
- **COMPARE**
  - One byte per cycle. Compare `lookahead[k]` against the source byte:
    - if `p+k<cur`, the source is `history[(p+k) mod HISTORY_SIZE]`;
    - otherwise the source is `lookahead[p+k-cur]` (overlapping copy).
  - Stop at the first mismatch, or when `k==18`, or when `k==avail`. Then `len=k`.
- **EMIT**
  - `out_valid=1` for one cycle.
  - If `len>=3`: `data_out={len-3, off[11:0]}`, `control_word_out=1`, `n=len`.
  - Otherwise: `data_out={8'h00, lookahead[0]}`, `control_word_out=0`, `n=1`.
- **COMMIT**
  - `n` cycles. Each cycle writes `lookahead[0]` to `history[cur]`, then shifts the lookahead by one, `cur++`, `avail--`.
  - Then go to FILL.
- No input is accepted outside FILL.

**Boundary conditions**
- A byte carrying `data_in_last` is the final byte. Later bytes are not accepted until `done` has been pulsed.
- The hash table is updated only at item-start positions.
- Lengths are limited to 3..18. A match of length below 3 is discarded and a literal is emitted.
- Positions wrap modulo `HISTORY_SIZE` in the history RAM. Offsets are computed in 16-bit arithmetic.

## Timing
- **Reset values:** `compressor_busy=0`, `data_out=16'h0000`, `control_word_out=0`, `out_valid=0`, `done=0`, state FILL, `cur=0`, `avail=0`, hash valid bits=0.
- **Reset mid-operation:** the current frame is abandoned and no partial item is emitted. The history RAM is not cleared and does not need to be.
- `data_out` and `control_word_out` hold their value from the EMIT cycle until the next EMIT.
- **Literal latency** (`avail>=3`): FILL exit -> HASH 1 cycle -> LOOKUP 1 cycle -> EMIT. `out_valid` appears 2 cycles after the last FILL cycle, plus the COMPARE cycles if a candidate was valid.
- **Tail latency:** when `avail<3`, `out_valid` appears 1 cycle after HASH.
- `done` is asserted in the cycle after the final COMMIT completes (FILL with `avail==0`).
- `compressor_busy` deasserts in the first FILL cycle.

## Test plan
1. **Literals only.** Frame "ABC" (`last` on C) -> `0x0041`, `0x0042`, `0x0043`, each with `cw=0`, then one `done` pulse.
2. **Basic copy.** Frame "abcabcabc" -> literals `0x0061`, `0x0062`, `0x0063`, then a copy `0x3003` with `cw=1` (offset 3, length 6), then `done`. Exactly 4 `out_valid` pulses.
3. **Overlapping maximal copy.** 20 x 'A' -> literal `0x0041`, copy `0xF001` (offset 1, length 18), literal `0x0041`, then `done`.
4. **Busy handshake.** Drive `data_in=0xFF` with `data_in_valid=1` throughout the cycles where `compressor_busy=1`, around the bytes of test 1 -> output identical to test 1. No `0x00FF` item appears.
5. **Reset mid-compare.** Assert `reset` while in COMPARE on frame "abcabc" -> all outputs return to 0 immediately and no `out_valid` occurs. Then frame "XY" -> `0x0058`, `0x0059` with `cw=0`, then `done`.
6. **Window limit.** With `HISTORY_SIZE=32`, send "xyz", then 40 bytes `0x01`..`0x28`, then "xyz" -> the final "xyz" is emitted as 3 literals, because the offset of 43 exceeds 31.

Source files
------------

// File: rtl/lzrw1_compressor.sv
// Streaming LZRW1 compressor: hashes 3-byte prefixes into a position table and
// emits one literal or copy item per match attempt from an 18-byte lookahead.
module lzrw1_compressor #(
   parameter int HISTORY_SIZE = 256,
   parameter int HASH_ENTRIES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        data_in_valid,
   input  logic        data_in_last,
   output logic        compressor_busy,
   output logic [15:0] data_out,
   output logic        control_word_out,
   output logic        out_valid,
   output logic        done
);

   localparam int HB = $clog2(HISTORY_SIZE);
   localparam int HW = $clog2(HASH_ENTRIES);
   localparam int LA = 18;
   localparam logic [15:0] MAX_OFF = 16'(HISTORY_SIZE - 1);

   localparam logic [2:0] FILL    = 3'd0;
   localparam logic [2:0] HASH    = 3'd1;
   localparam logic [2:0] LOOKUP  = 3'd2;
   localparam logic [2:0] COMPARE = 3'd3;
   localparam logic [2:0] EMIT    = 3'd4;
   localparam logic [2:0] COMMIT  = 3'd5;

   logic [2:0]              state;
   logic [7:0]              la [LA];
   logic [4:0]              avail, k, cnt;
   logic [15:0]             cur, p;
   logic [11:0]             off;
   logic                    p_valid, last_seen;
   logic [HW-1:0]           h;
   logic [HASH_ENTRIES-1:0] hvalid;
   logic [15:0]             tbl  [HASH_ENTRIES];
   logic [7:0]              hist [HISTORY_SIZE];

   logic [7:0]  hraw;
   logic [HW-1:0] h_next;
   logic [15:0] pk, off_next;
   logic [4:0]  lidx, k1, clen;
   logic [3:0]  clen_code;
   logic [7:0]  src;
   logic        hit, stop, miss, accept;

   assign compressor_busy = !(state == FILL && avail < 5'd18 && !last_seen);
   assign out_valid       = (state == EMIT);
   assign done            = (state == FILL) && last_seen && (avail == 5'd0);
   assign accept          = data_in_valid && !compressor_busy;

   always_comb begin
      hraw     = la[0] ^ {la[1][3:0], la[1][7:4]} ^ {la[2][1:0], la[2][7:2]};
      h_next   = HW'(hraw);
      off_next = cur - p;
      miss     = !p_valid || off_next == 16'd0 || off_next > MAX_OFF;
      pk       = p + {11'd0, k};
      // Source at or beyond cur lies in the lookahead itself (overlapping copy)
      lidx     = pk[4:0] - cur[4:0];
      src      = (pk < cur) ? hist[pk[HB-1:0]] : la[lidx];
      hit      = (src == la[k]);
      k1       = k + 5'd1;
      stop     = !hit || k1 == 5'd18 || k1 == avail;
      clen     = hit ? k1 : k;
      clen_code = clen[3:0] - 4'd3;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= FILL;
         avail            <= '0;
         cur              <= '0;
         last_seen        <= 1'b0;
         hvalid           <= '0;
         k                <= '0;
         cnt              <= '0;
         p                <= '0;
         p_valid          <= 1'b0;
         off              <= '0;
         h                <= '0;
         data_out         <= '0;
         control_word_out <= 1'b0;
         for (int i = 0; i < LA; i++) la[i] <= '0;
      end else begin
         case (state)
            FILL: begin
               if (done) begin
                  cur       <= '0;
                  hvalid    <= '0;
                  last_seen <= 1'b0;
               end else if (avail == 5'd18 || last_seen) begin
                  state <= HASH;
               end else if (accept) begin
                  la[avail] <= data_in;
                  avail     <= avail + 5'd1;
                  if (data_in_last) last_seen <= 1'b1;
               end
            end
            HASH: begin
               if (avail < 5'd3) begin
                  data_out         <= {8'h00, la[0]};
                  control_word_out <= 1'b0;
                  cnt              <= 5'd1;
                  state            <= EMIT;
               end else begin
                  h       <= h_next;
                  p       <= tbl[h_next];
                  p_valid <= hvalid[h_next];
                  state   <= LOOKUP;
               end
            end
            LOOKUP: begin
               hvalid[h] <= 1'b1;
               off       <= off_next[11:0];
               if (miss) begin
                  data_out         <= {8'h00, la[0]};
                  control_word_out <= 1'b0;
                  cnt              <= 5'd1;
                  state            <= EMIT;
               end else begin
                  k     <= '0;
                  state <= COMPARE;
               end
            end
            COMPARE: begin
               if (stop) begin
                  if (clen >= 5'd3) begin
                     data_out         <= {clen_code, off};
                     control_word_out <= 1'b1;
                     cnt              <= clen;
                  end else begin
                     data_out         <= {8'h00, la[0]};
                     control_word_out <= 1'b0;
                     cnt              <= 5'd1;
                  end
                  state <= EMIT;
               end else begin
                  k <= k1;
               end
            end
            EMIT: state <= COMMIT;
            COMMIT: begin
               for (int i = 0; i < LA - 1; i++) la[i] <= la[i+1];
               la[LA-1] <= '0;
               cur      <= cur + 16'd1;
               avail    <= avail - 5'd1;
               cnt      <= cnt - 5'd1;
               if (cnt == 5'd1) state <= FILL;
            end
            default: state <= FILL;
         endcase
      end
   end

   // Storage arrays carry no reset; the hash valid vector guards stale entries
   always_ff @(posedge clock) begin
      if (state == LOOKUP) tbl[h] <= cur;
      if (state == COMMIT) hist[cur[HB-1:0]] <= la[0];
   end

endmodule

// File: tb/tb_lzrw1_compressor.sv
// Scoreboard bench for lzrw1_compressor: expected items are queued as frames are
// driven and popped by a monitor as the selected instance emits them.
module tb_lzrw1_compressor;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        din_valid = 1'b0;
   logic        din_last = 1'b0;
   logic        sel = 1'b0;

   logic        valid_a, valid_b;
   logic        busy_a, busy_b, ov_a, ov_b, cw_a, cw_b, done_a, done_b;
   logic [15:0] do_a, do_b;
   logic        busy_s, ov_s, cw_s, done_s, ov_o, done_o;
   logic [15:0] do_s;

   assign valid_a = din_valid && !sel;
   assign valid_b = din_valid && sel;
   assign busy_s  = sel ? busy_b : busy_a;
   assign ov_s    = sel ? ov_b   : ov_a;
   assign cw_s    = sel ? cw_b   : cw_a;
   assign done_s  = sel ? done_b : done_a;
   assign do_s    = sel ? do_b   : do_a;
   assign ov_o    = sel ? ov_a   : ov_b;
   assign done_o  = sel ? done_a : done_b;

   lzrw1_compressor dut_a (
      .clock(clock), .reset(reset), .data_in(data_in), .data_in_valid(valid_a),
      .data_in_last(din_last), .compressor_busy(busy_a), .data_out(do_a),
      .control_word_out(cw_a), .out_valid(ov_a), .done(done_a));

   lzrw1_compressor #(.HISTORY_SIZE(32), .HASH_ENTRIES(64)) dut_b (
      .clock(clock), .reset(reset), .data_in(data_in), .data_in_valid(valid_b),
      .data_in_last(din_last), .compressor_busy(busy_b), .data_out(do_b),
      .control_word_out(cw_b), .out_valid(ov_b), .done(done_b));

   always #5 clock = ~clock;

   typedef struct packed {
      logic        is_done;
      logic        cw;
      logic [15:0] data;
   } item_t;

   item_t      exp_q[$];
   logic [7:0] frame_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   always @(negedge clock) begin
      if (reset) begin
         if (ov_s || done_s) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_output: got ov=%0b done=%0b data=%h cw=%0b, required no output",
                        ov_s, done_s, do_s, cw_s);
            end else begin
               item_t e;
               e = exp_q.pop_front();
               if (ov_s && (e.is_done || do_s !== e.data || cw_s !== e.cw)) begin
                  n_bad++;
                  $display("FAIL item: got data=%h cw=%0b, required %s data=%h cw=%0b",
                           do_s, cw_s, e.is_done ? "done" : "item", e.data, e.cw);
               end else if (!ov_s && done_s && !e.is_done) begin
                  n_bad++;
                  $display("FAIL early_done: got done, required item data=%h cw=%0b", e.data, e.cw);
               end
            end
         end
         if (ov_o || done_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_instance: got ov=%0b done=%0b, required silence", ov_o, done_o);
         end
      end
   end

   task automatic expect_item(input logic cw, input logic [15:0] d);
      exp_q.push_back('{is_done: 1'b0, cw: cw, data: d});
   endtask

   task automatic expect_done();
      exp_q.push_back('{is_done: 1'b1, cw: 1'b0, data: 16'h0000});
   endtask

   // Called at a negedge; returns at the negedge right after the byte is taken.
   // In junk mode 0xFF is offered whenever the core reports busy.
   task automatic send(input logic [7:0] b, input logic last, input bit junk);
      int t = 0;
      while (busy_s && t < 500) begin
         data_in   = 8'hFF;
         din_valid = junk;
         din_last  = 1'b0;
         @(negedge clock);
         t++;
      end
      if (t >= 500) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got busy for %0d cycles, required acceptance", t);
      end
      data_in   = b;
      din_valid = 1'b1;
      din_last  = last;
      @(negedge clock);
      data_in   = 8'hFF;
      din_valid = junk;
      din_last  = 1'b0;
   endtask

   task automatic send_frame(input bit junk);
      int t = 0;
      for (int i = 0; i < frame_q.size(); i++)
         send(frame_q[i], i == frame_q.size() - 1, junk);
      while (t < 3000) begin
         @(negedge clock);
         t++;
         if (done_s) break;
      end
      din_valid = 1'b0;
      #1;
      n_cmp++;
      if (t >= 3000 || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL frame_end: got %0d items outstanding after %0d cycles, required 0 and done",
                  exp_q.size(), t);
      end
      exp_q.delete();
      @(negedge clock);
   endtask

   task automatic test_reset();
      sel = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      n_cmp += 4;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         n_bad++; $display("FAIL reset_busy: got %0b/%0b, required 0/0", busy_a, busy_b);
      end
      if (do_a !== 16'h0000 || do_b !== 16'h0000) begin
         n_bad++; $display("FAIL reset_data: got %h/%h, required 0000/0000", do_a, do_b);
      end
      if (cw_a !== 1'b0 || ov_a !== 1'b0 || cw_b !== 1'b0 || ov_b !== 1'b0) begin
         n_bad++; $display("FAIL reset_valid: got cw=%0b ov=%0b, required 0", cw_a | cw_b, ov_a | ov_b);
      end
      if (done_a !== 1'b0 || done_b !== 1'b0) begin
         n_bad++; $display("FAIL reset_done: got %0b/%0b, required 0/0", done_a, done_b);
      end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_literals(input bit junk);
      expect_item(1'b0, 16'h0041);
      expect_item(1'b0, 16'h0042);
      expect_item(1'b0, 16'h0043);
      expect_done();
      frame_q = {8'h41, 8'h42, 8'h43};
      send_frame(junk);
   endtask

   task automatic test_copy();
      expect_item(1'b0, 16'h0061);
      expect_item(1'b0, 16'h0062);
      expect_item(1'b0, 16'h0063);
      expect_item(1'b1, 16'h3003);
      expect_done();
      frame_q = {8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
      send_frame(1'b0);
   endtask

   task automatic test_overlap(input bit junk);
      expect_item(1'b0, 16'h0041);
      expect_item(1'b1, 16'hF001);
      expect_item(1'b0, 16'h0041);
      expect_done();
      frame_q.delete();
      for (int i = 0; i < 20; i++) frame_q.push_back(8'h41);
      send_frame(junk);
   endtask

   task automatic test_busy();
      test_literals(1'b1);
      test_overlap(1'b1);
   endtask

   task automatic test_reset_mid_compare();
      int t = 0;
      sel = 1'b0;
      expect_item(1'b0, 16'h0061);
      expect_item(1'b0, 16'h0062);
      expect_item(1'b0, 16'h0063);
      frame_q = {8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
      for (int i = 0; i < frame_q.size(); i++) send(frame_q[i], i == frame_q.size() - 1, 1'b0);
      while (dut_a.state != 3'd3 && t < 500) begin
         @(negedge clock);
         t++;
      end
      #1 reset = 1'b0;
      #1;
      n_cmp += 3;
      if (t >= 500 || exp_q.size() != 0) begin
         n_bad++; $display("FAIL mid_reach_compare: got %0d pending after %0d cycles, required 0", exp_q.size(), t);
      end
      if (do_a !== 16'h0000 || cw_a !== 1'b0 || ov_a !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset_out: got data=%h cw=%0b ov=%0b, required 0", do_a, cw_a, ov_a);
      end
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset_ctl: got busy=%0b done=%0b, required 0", busy_a, done_a);
      end
      exp_q.delete();
      repeat (3) begin
         @(negedge clock);
         n_cmp++;
         if (ov_a !== 1'b0 || done_a !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_hold: got ov=%0b done=%0b, required 0", ov_a, done_a);
         end
      end
      reset = 1'b1;
      repeat (4) @(negedge clock);
      expect_item(1'b0, 16'h0058);
      expect_item(1'b0, 16'h0059);
      expect_done();
      frame_q = {8'h58, 8'h59};
      send_frame(1'b0);
   endtask

   task automatic test_window();
      sel = 1'b1;
      @(negedge clock);
      frame_q = {8'h78, 8'h79, 8'h7A};
      for (int i = 1; i <= 40; i++) frame_q.push_back(8'(i));
      frame_q.push_back(8'h78);
      frame_q.push_back(8'h79);
      frame_q.push_back(8'h7A);
      for (int i = 0; i < frame_q.size(); i++) expect_item(1'b0, {8'h00, frame_q[i]});
      expect_done();
      send_frame(1'b0);
      sel = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_literals(1'b0);
      test_copy();
      test_overlap(1'b0);
      test_busy();
      test_reset_mid_compare();
      test_window();
      test_copy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
